// File: rtl/wb_scoreboard.sv
// In-order completion tracker: allocates sids, records writebacks, retires up to two oldest done entries per cycle.
// Retire is combinational from registered state (writeback to retire is one cycle); alloc_ready_o drops below two free entries or on redirect.
module wb_scoreboard #(
    parameter int SB_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc0_valid_i,
    input  logic [4:0]        alloc0_rd_i,
    input  logic              alloc1_valid_i,
    input  logic [4:0]        alloc1_rd_i,
    output logic              alloc_ready_o,
    output logic [SB_AW:0]    alloc0_sid_o,
    output logic [SB_AW:0]    alloc1_sid_o,
    input  logic              wb0_valid_i,
    input  logic [SB_AW:0]    wb0_sid_i,
    input  logic [63:0]       wb0_value_i,
    input  logic              wb1_valid_i,
    input  logic [SB_AW:0]    wb1_sid_i,
    input  logic [63:0]       wb1_value_i,
    input  logic              redirect_i,
    input  logic [SB_AW:0]    redirect_sid_i,
    output logic              retire0_valid_o,
    output logic [4:0]        retire0_rd_o,
    output logic [63:0]       retire0_value_o,
    output logic [SB_AW:0]    retire0_sid_o,
    output logic              retire1_valid_o,
    output logic [4:0]        retire1_rd_o,
    output logic [63:0]       retire1_value_o,
    output logic [SB_AW:0]    retire1_sid_o,
    output logic [31:0]       rd_busy_o,
    output logic [SB_AW:0]    count_o
);
    localparam int SW    = SB_AW + 1;
    localparam int DEPTH = 2 ** SB_AW;
    localparam logic [SW-1:0] LP_ONE     = SW'(1);
    localparam logic [SW-1:0] LP_TWO     = SW'(2);
    localparam logic [SW-1:0] LP_RDY_MAX = SW'(DEPTH - 2);

    logic [DEPTH-1:0] r_vld;
    logic [DEPTH-1:0] r_done;
    logic [4:0]       r_rd  [DEPTH];
    logic [63:0]      r_val [DEPTH];
    logic [SW-1:0]    r_head;
    logic [SW-1:0]    r_tail;

    logic [SW-1:0]    w_count;
    logic [SW-1:0]    w_head1;
    logic [SB_AW-1:0] w_h0;
    logic [SB_AW-1:0] w_h1;
    logic [SW-1:0]    w_redir_rel;
    logic             w_redir_ok;
    logic [SW-1:0]    w_wb0_rel;
    logic [SW-1:0]    w_wb1_rel;
    logic             w_wb0_ok;
    logic             w_wb1_ok;
    logic             w_alloc0;
    logic             w_alloc1;
    logic [SW-1:0]    w_nret;
    logic [SW-1:0]    w_nalloc;
    logic [DEPTH-1:0] w_clr;
    logic [31:0]      w_busy;
    logic [SB_AW-1:0] w_off;
    logic             w_live;

    assign w_count = r_tail - r_head;
    assign w_head1 = r_head + LP_ONE;
    assign w_h0    = r_head[SB_AW-1:0];
    assign w_h1    = w_head1[SB_AW-1:0];

    // Window membership is the distance from head compared against the live count, so it survives pointer wrap.
    assign w_redir_rel = redirect_sid_i - r_head;
    assign w_redir_ok  = redirect_i && (w_redir_rel < w_count);
    assign w_wb0_rel   = wb0_sid_i - r_head;
    assign w_wb1_rel   = wb1_sid_i - r_head;
    assign w_wb0_ok    = wb0_valid_i && (w_wb0_rel < w_count) && (!w_redir_ok || (w_wb0_rel <= w_redir_rel));
    assign w_wb1_ok    = wb1_valid_i && (w_wb1_rel < w_count) && (!w_redir_ok || (w_wb1_rel <= w_redir_rel));

    assign alloc_ready_o = (w_count <= LP_RDY_MAX) && !redirect_i;
    assign alloc0_sid_o  = r_tail;
    assign alloc1_sid_o  = r_tail + LP_ONE;
    assign w_alloc0      = alloc_ready_o && alloc0_valid_i;
    assign w_alloc1      = w_alloc0 && alloc1_valid_i;

    // A redirect on the head sid squashes head+1, so it must not retire alongside head.
    assign retire0_valid_o = (w_count != '0) && r_done[w_h0];
    assign retire1_valid_o = retire0_valid_o && (w_count >= LP_TWO) && r_done[w_h1]
                             && !(w_redir_ok && (w_redir_rel == '0));
    assign retire0_rd_o    = r_rd[w_h0];
    assign retire0_value_o = r_val[w_h0];
    assign retire0_sid_o   = r_head;
    assign retire1_rd_o    = r_rd[w_h1];
    assign retire1_value_o = r_val[w_h1];
    assign retire1_sid_o   = w_head1;

    assign w_nret   = SW'(retire0_valid_o) + SW'(retire1_valid_o);
    assign w_nalloc = SW'(w_alloc0) + SW'(w_alloc1);
    assign count_o  = w_count;
    assign rd_busy_o = w_busy;

    always_comb begin
        w_clr  = '0;
        w_busy = '0;
        w_off  = '0;
        w_live = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off  = SB_AW'(i) - w_h0;
            w_live = ({1'b0, w_off} < w_count);
            if ((retire0_valid_o && (w_h0 == SB_AW'(i))) ||
                (retire1_valid_o && (w_h1 == SB_AW'(i))) ||
                (w_redir_ok && w_live && ({1'b0, w_off} > w_redir_rel))) begin
                w_clr[i] = 1'b1;
            end
            if (r_vld[i] && (r_rd[i] != 5'd0)) begin
                w_busy[r_rd[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_vld  <= '0;
            r_done <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rd[i]  <= '0;
                r_val[i] <= '0;
            end
        end else begin
            r_head <= r_head + w_nret;
            r_tail <= w_redir_ok ? (redirect_sid_i + LP_ONE) : (r_tail + w_nalloc);
            // Later statements win: wb0 over wb1 on a shared sid, and clear over everything.
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wb1_ok && (wb1_sid_i[SB_AW-1:0] == SB_AW'(i))) begin
                    r_done[i] <= 1'b1;
                    r_val[i]  <= wb1_value_i;
                end
                if (w_wb0_ok && (wb0_sid_i[SB_AW-1:0] == SB_AW'(i))) begin
                    r_done[i] <= 1'b1;
                    r_val[i]  <= wb0_value_i;
                end
                if (w_alloc0 && (alloc0_sid_o[SB_AW-1:0] == SB_AW'(i))) begin
                    r_vld[i]  <= 1'b1;
                    r_done[i] <= 1'b0;
                    r_rd[i]   <= alloc0_rd_i;
                end
                if (w_alloc1 && (alloc1_sid_o[SB_AW-1:0] == SB_AW'(i))) begin
                    r_vld[i]  <= 1'b1;
                    r_done[i] <= 1'b0;
                    r_rd[i]   <= alloc1_rd_i;
                end
                if (w_clr[i]) begin
                    r_vld[i]  <= 1'b0;
                    r_done[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_wb_scoreboard.sv
// Directed bench for wb_scoreboard: stimulus queues expected retirements, a negedge monitor pops and compares them.
module tb_wb_scoreboard;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        alloc0_valid_i, alloc1_valid_i, alloc_ready_o;
    logic [4:0]  alloc0_rd_i, alloc1_rd_i;
    logic [3:0]  alloc0_sid_o, alloc1_sid_o;
    logic        wb0_valid_i, wb1_valid_i;
    logic [3:0]  wb0_sid_i, wb1_sid_i;
    logic [63:0] wb0_value_i, wb1_value_i;
    logic        redirect_i;
    logic [3:0]  redirect_sid_i;
    logic        retire0_valid_o, retire1_valid_o;
    logic [4:0]  retire0_rd_o, retire1_rd_o;
    logic [63:0] retire0_value_o, retire1_value_o;
    logic [3:0]  retire0_sid_o, retire1_sid_o;
    logic [31:0] rd_busy_o;
    logic [3:0]  count_o;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] val;
        logic [3:0]  sid;
    } ret_t;

    ret_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    wb_scoreboard #(.SB_AW(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc0_valid_i(alloc0_valid_i), .alloc0_rd_i(alloc0_rd_i),
        .alloc1_valid_i(alloc1_valid_i), .alloc1_rd_i(alloc1_rd_i),
        .alloc_ready_o(alloc_ready_o), .alloc0_sid_o(alloc0_sid_o), .alloc1_sid_o(alloc1_sid_o),
        .wb0_valid_i(wb0_valid_i), .wb0_sid_i(wb0_sid_i), .wb0_value_i(wb0_value_i),
        .wb1_valid_i(wb1_valid_i), .wb1_sid_i(wb1_sid_i), .wb1_value_i(wb1_value_i),
        .redirect_i(redirect_i), .redirect_sid_i(redirect_sid_i),
        .retire0_valid_o(retire0_valid_o), .retire0_rd_o(retire0_rd_o),
        .retire0_value_o(retire0_value_o), .retire0_sid_o(retire0_sid_o),
        .retire1_valid_o(retire1_valid_o), .retire1_rd_o(retire1_rd_o),
        .retire1_value_o(retire1_value_o), .retire1_sid_o(retire1_sid_o),
        .rd_busy_o(rd_busy_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_ret(input string name, input logic [4:0] rd, input logic [63:0] v, input logic [3:0] sid);
        ret_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s: unexpected retire rd %0d val %0h sid %0d, nothing expected", name, rd, v, sid);
        end else begin
            e = exp_q.pop_front();
            if ({rd, v, sid} !== e) begin
                n_errors++;
                $display("FAIL %s: got rd %0d val %0h sid %0d, expected rd %0d val %0h sid %0d",
                         name, rd, v, sid, e.rd, e.val, e.sid);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (retire0_valid_o) check_ret("retire0", retire0_rd_o, retire0_value_o, retire0_sid_o);
            if (retire1_valid_o) check_ret("retire1", retire1_rd_o, retire1_value_o, retire1_sid_o);
        end
    end

    task automatic expect_ret(input logic [4:0] rd, input logic [63:0] v, input logic [3:0] sid);
        exp_q.push_back(ret_t'({rd, v, sid}));
    endtask

    task automatic do_alloc(input logic v0, input logic [4:0] rd0, input logic v1, input logic [4:0] rd1);
        alloc0_valid_i = v0; alloc0_rd_i = rd0;
        alloc1_valid_i = v1; alloc1_rd_i = rd1;
    endtask

    task automatic do_wb0(input logic [3:0] sid, input logic [63:0] v);
        wb0_valid_i = 1'b1; wb0_sid_i = sid; wb0_value_i = v;
    endtask

    task automatic do_wb1(input logic [3:0] sid, input logic [63:0] v);
        wb1_valid_i = 1'b1; wb1_sid_i = sid; wb1_value_i = v;
    endtask

    task automatic do_redir(input logic [3:0] sid);
        redirect_i = 1'b1; redirect_sid_i = sid;
    endtask

    task automatic clear_in();
        do_alloc(1'b0, 5'd0, 1'b0, 5'd0);
        wb0_valid_i = 1'b0; wb0_sid_i = '0; wb0_value_i = '0;
        wb1_valid_i = 1'b0; wb1_sid_i = '0; wb1_value_i = '0;
        redirect_i = 1'b0; redirect_sid_i = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_in();
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] s0, s1;
        rst_n = 1'b0;
        clear_in();
        #12;
        chk("reset count", count_o, 0);
        chk("reset busy", rd_busy_o, 0);
        chk("reset ready", alloc_ready_o, 1);
        chk("reset retire0", retire0_valid_o, 0);
        chk("reset retire1", retire1_valid_o, 0);
        rst_n = 1'b1;

        // Pair alloc, out-of-order writeback, dual retire
        do_alloc(1, 5'd5, 1, 5'd6);
        #1;
        chk("s1 sid0", alloc0_sid_o, 0);
        chk("s1 sid1", alloc1_sid_o, 1);
        tick();
        chk("s1 count", count_o, 2);
        chk("s1 busy", rd_busy_o, 32'h60);
        chk("s1 no retire", retire0_valid_o, 0);
        do_wb1(4'd1, 64'h1111_0000_0000_0006);
        tick();
        chk("s1 head not done", retire0_valid_o, 0);
        expect_ret(5'd5, 64'h5555_0000_0000_0005, 4'd0);
        expect_ret(5'd6, 64'h1111_0000_0000_0006, 4'd1);
        do_wb0(4'd0, 64'h5555_0000_0000_0005);
        tick();
        chk("s1 retire1 same cycle", retire1_valid_o, 1);
        tick();
        chk("s1 drained count", count_o, 0);
        chk("s1 drained busy", rd_busy_o, 0);

        // Fill to full, readiness threshold, sid wrap
        for (int k = 0; k < 3; k++) begin
            do_alloc(1, 5'(1 + 2 * k), 1, 5'(2 + 2 * k));
            tick();
        end
        chk("s3 count6", count_o, 6);
        chk("s3 ready at 6", alloc_ready_o, 1);
        do_alloc(1, 5'd7, 1, 5'd8);
        tick();
        chk("s3 full count", count_o, 8);
        chk("s3 full ready", alloc_ready_o, 0);
        chk("s3 full busy", rd_busy_o, 32'h1FE);
        expect_ret(5'd1, 64'h102, 4'd2);
        do_wb0(4'd2, 64'h102);
        tick();
        tick();
        chk("s3 count7", count_o, 7);
        chk("s3 ready at 7", alloc_ready_o, 0);
        expect_ret(5'd2, 64'h103, 4'd3);
        do_wb0(4'd3, 64'h103);
        tick();
        tick();
        chk("s3 ready back", alloc_ready_o, 1);
        for (int k = 0; k < 3; k++) begin
            s0 = 4'(4 + 2 * k);
            s1 = 4'(5 + 2 * k);
            expect_ret(5'(s0 - 4'd1), 64'h100 + 64'(s0), s0);
            expect_ret(5'(s1 - 4'd1), 64'h100 + 64'(s1), s1);
            do_wb0(s0, 64'h100 + 64'(s0));
            do_wb1(s1, 64'h100 + 64'(s1));
            tick();
        end
        tick();
        tick();
        chk("s3 empty", count_o, 0);
        chk("s3 tail10", alloc0_sid_o, 10);
        for (int k = 0; k < 3; k++) begin
            do_alloc(1, 5'(9 + 2 * k), 1, 5'(10 + 2 * k));
            tick();
        end
        chk("s3 wrap sid0", alloc0_sid_o, 0);
        chk("s3 wrap sid1", alloc1_sid_o, 1);
        do_alloc(1, 5'd15, 1, 5'd16);
        tick();
        chk("s3 wrap full", count_o, 8);
        for (int k = 0; k < 4; k++) begin
            s0 = 4'(10 + 2 * k);
            s1 = 4'(11 + 2 * k);
            expect_ret(5'(9 + 2 * k), 64'h200 + 64'(s0), s0);
            expect_ret(5'(10 + 2 * k), 64'h200 + 64'(s1), s1);
            do_wb0(s0, 64'h200 + 64'(s0));
            do_wb1(s1, 64'h200 + 64'(s1));
            tick();
        end
        tick();
        tick();
        chk("s3 wrap drained", count_o, 0);
        chk("s3 tail2", alloc0_sid_o, 2);

        // Redirect squashes younger entries, blocks alloc, filters writebacks
        do_alloc(1, 5'd10, 1, 5'd11);
        tick();
        do_alloc(1, 5'd12, 1, 5'd13);
        tick();
        do_alloc(1, 5'd14, 0, 5'd0);
        tick();
        chk("s4 count5", count_o, 5);
        do_alloc(1, 5'd20, 1, 5'd21);
        do_redir(4'd3);
        do_wb0(4'd5, 64'hDEAD);
        expect_ret(5'd10, 64'h302, 4'd2);
        do_wb1(4'd2, 64'h302);
        #1;
        chk("s4 ready on redirect", alloc_ready_o, 0);
        tick();
        chk("s4 count", count_o, 2);
        chk("s4 busy", rd_busy_o, 32'h0C00);
        chk("s4 tail", alloc0_sid_o, 4);
        tick();
        chk("s4 after retire count", count_o, 1);
        chk("s4 after retire busy", rd_busy_o, 32'h0800);
        expect_ret(5'd11, 64'h303, 4'd3);
        do_wb0(4'd3, 64'h303);
        tick();
        tick();
        chk("s4 drained", count_o, 0);
        do_redir(4'd7);
        #1;
        chk("s4 ready oow redirect", alloc_ready_o, 0);
        tick();
        chk("s4 oow count", count_o, 0);
        chk("s4 oow tail", alloc0_sid_o, 4);

        // Retire, writeback and alloc in the same cycle
        do_alloc(1, 5'd1, 1, 5'd2);
        tick();
        expect_ret(5'd1, 64'h404, 4'd4);
        do_wb0(4'd4, 64'h404);
        tick();
        expect_ret(5'd2, 64'h405, 4'd5);
        do_wb0(4'd5, 64'h405);
        do_alloc(1, 5'd3, 0, 5'd0);
        #1;
        chk("s5 retire head", retire0_valid_o, 1);
        chk("s5 alloc sid", alloc0_sid_o, 6);
        tick();
        chk("s5 count unchanged", count_o, 2);
        chk("s5 tail", alloc0_sid_o, 7);
        chk("s5 next retire sid", retire0_sid_o, 5);
        chk("s5 no retire1", retire1_valid_o, 0);
        tick();
        expect_ret(5'd3, 64'h406, 4'd6);
        do_wb0(4'd6, 64'h406);
        tick();
        tick();
        chk("s5 drained", count_o, 0);

        // Asynchronous reset with live entries
        do_alloc(1, 5'd21, 1, 5'd22);
        tick();
        do_alloc(1, 5'd23, 1, 5'd24);
        tick();
        chk("s6 count4", count_o, 4);
        chk("s6 busy", rd_busy_o, 32'h01E0_0000);
        do_wb0(4'd8, 64'h508);
        tick();
        rst_n = 1'b0;
        #1;
        chk("s6 rst count", count_o, 0);
        chk("s6 rst busy", rd_busy_o, 0);
        chk("s6 rst retire", retire0_valid_o, 0);
        chk("s6 rst ready", alloc_ready_o, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        chk("s6 post sid", alloc0_sid_o, 0);
        chk("s6 post count", count_o, 0);
        do_alloc(1, 5'd1, 1, 5'd2);
        tick();
        do_wb1(4'd1, 64'h601);
        tick();
        tick();
        chk("s6 head pending", retire0_valid_o, 0);
        expect_ret(5'd1, 64'h600, 4'd0);
        expect_ret(5'd2, 64'h601, 4'd1);
        do_wb0(4'd0, 64'h600);
        tick();
        tick();
        chk("s6 drained", count_o, 0);

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        chk("queue drained", 64'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
